mul_fp_single_seq: RTL and testbench



---
 rtl/mul_fp_single_seq.sv | 203 ++++++++++++++++++++
 tb/tb_mul_fp_single_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_fp_single_seq.sv
// Sequential IEEE-754 single-precision multiplier.
// Shift-and-add mantissa product, BPC multiplier bits per cycle.
module mul_fp_single_seq #(
  parameter int BPC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        ovf,
  output logic        unf
);

  localparam int N  = 24 / BPC;
  localparam int PW = 48 + BPC;

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 3 ||
          BPC == 4 || BPC == 6 || BPC == 8 ||
          BPC == 12 || BPC == 24)) begin : g_bad_bpc
      $error("mul_fp_single_seq: illegal BPC");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [23:0] mcand;
  logic [23:0] mplier;
  logic [47:0] prod;
  logic [4:0]  cnt;
  logic [7:0]  ea, eb;
  logic        so;

  logic [7:0]  xa, xb;
  logic [22:0] fa, fb;
  logic        sn;
  logic        nan_a, nan_b;
  logic        inf_a, inf_b;
  logic        zer_a, zer_b;
  logic        is_nan, is_ixz;
  logic        is_inf, is_zer;
  logic        spec;
  logic [31:0] spec_out;

  assign xa = a[30:23];
  assign xb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];
  assign sn = a[31] ^ b[31];

  assign nan_a = (xa == 8'hFF) && (fa != 23'd0);
  assign nan_b = (xb == 8'hFF) && (fb != 23'd0);
  assign inf_a = (xa == 8'hFF) && (fa == 23'd0);
  assign inf_b = (xb == 8'hFF) && (fb == 23'd0);
  assign zer_a = (xa == 8'd0);
  assign zer_b = (xb == 8'd0);

  // Classes made mutually exclusive in priority order
  assign is_nan = nan_a | nan_b;
  assign is_ixz = !is_nan &
                  ((inf_a & zer_b) | (inf_b & zer_a));
  assign is_inf = !is_nan && !is_ixz &&
                  (inf_a | inf_b);
  assign is_zer = !is_nan && !(inf_a | inf_b) &&
                  (zer_a | zer_b);

  always_comb begin
    spec     = 1'b1;
    spec_out = 32'd0;
    unique case (1'b1)
      is_nan:  spec_out = 32'h7FC0_0000;
      is_ixz:  spec_out = 32'h7FC0_0000;
      is_inf:  spec_out = {sn, 8'hFF, 23'd0};
      is_zer:  spec_out = {sn, 31'd0};
      default: spec = 1'b0;
    endcase
  end

  logic [BPC-1:0]  dig;
  logic [23+BPC:0] part;
  logic [PW-1:0]   sum;
  logic [47:0]     prod_nx;

  assign dig     = mplier[BPC-1:0];
  assign part    = {{BPC{1'b0}}, mcand} *
                   {{24{1'b0}}, dig};
  assign sum     = {{BPC{1'b0}}, prod} +
                   {part, 24'd0};
  assign prod_nx = sum[PW-1:BPC];

  logic signed [9:0] e0, e1;
  logic [22:0]       mant;
  logic [31:0]       nres;
  logic              novf, nunf;

  assign e0   = {2'b00, ea} + {2'b00, eb} - 10'd127;
  assign e1   = prod[47] ? e0 + 10'sd1 : e0;
  assign mant = prod[47] ? prod[46:24] : prod[45:23];

  always_comb begin
    nres = {so, e1[7:0], mant};
    novf = 1'b0;
    nunf = 1'b0;
    if (e1 >= 10'sd255) begin
      nres = {so, 8'hFF, 23'd0};
      novf = 1'b1;
    end else if (e1 <= 10'sd0) begin
      nres = {so, 31'd0};
      nunf = 1'b1;
    end
  end

  logic unused;
  assign unused = ^{prod[22:0], sum[BPC-1:0]};

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = spec ? DONE : MUL;
      end
      MUL: begin
        if (cnt == 5'd1)
          state_nx = NORM;
      end
      NORM: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      ea     <= '0;
      eb     <= '0;
      so     <= 1'b0;
      out    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            so  <= sn;
            ea  <= xa;
            eb  <= xb;
            ovf <= 1'b0;
            unf <= 1'b0;
            if (spec) begin
              out <= spec_out;
            end else begin
              mcand  <= {1'b1, fa};
              mplier <= {1'b1, fb};
              prod   <= '0;
              cnt    <= 5'(N);
            end
          end
        end
        MUL: begin
          prod   <= prod_nx;
          mplier <= mplier >> BPC;
          cnt    <= cnt - 5'd1;
        end
        NORM: begin
          out <= nres;
          ovf <= novf;
          unf <= nunf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_fp_single_seq.sv
// Directed bench for mul_fp_single_seq.
// Checks BPC=1 and BPC=8 instances.
module tb_mul_fp_single_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv1, ir1, ov1, rd1, ovf1, unf1;
  logic [31:0] a1, b1, o1;
  logic        iv8, ir8, ov8, rd8, ovf8, unf8;
  logic [31:0] a8, b8, o8;

  mul_fp_single_seq #(.BPC(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(rd1),
    .out(o1), .ovf(ovf1), .unf(unf1)
  );

  mul_fp_single_seq #(.BPC(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(rd8),
    .out(o8), .ovf(ovf8), .unf(unf8)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic do_op(input bit s8,
                       input logic [31:0] ia,
                       input logic [31:0] ib,
                       output logic [31:0] ro,
                       output logic rovf,
                       output logic runf,
                       output int lat);
    int w;
    w = 0;
    while (!(s8 ? ir8 : ir1) && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) begin
      total++;
      bad++;
      $display("FAIL in_ready timeout: got 0 want 1");
    end
    if (s8) begin
      iv8 = 1'b1; a8 = ia; b8 = ib;
    end else begin
      iv1 = 1'b1; a1 = ia; b1 = ib;
    end
    @(posedge clk); #1;
    iv1 = 1'b0;
    iv8 = 1'b0;
    lat = 1;
    while (!(s8 ? ov8 : ov1) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ro   = s8 ? o8 : o1;
    rovf = s8 ? ovf8 : ovf1;
    runf = s8 ? unf8 : unf1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  localparam int NV = 10;
  vec_t v[NV];

  initial begin
    #200000;
    $display("FAIL global timeout: got running want done");
    $fatal(1);
  end

  initial begin
    logic [31:0] ro;
    logic        rovf, runf;
    int          lat;
    int          w;
    int          seen;

    v[0] = '{32'h40000000, 32'h40400000,
             32'h40C00000, 1'b0, 1'b0, 26};
    v[1] = '{32'h3FC00000, 32'h3FC00000,
             32'h40100000, 1'b0, 1'b0, 26};
    v[2] = '{32'hC0000000, 32'h3F000000,
             32'hBF800000, 1'b0, 1'b0, 26};
    v[3] = '{32'h7F000000, 32'h7F000000,
             32'h7F800000, 1'b1, 1'b0, 26};
    v[4] = '{32'h00800000, 32'h00800000,
             32'h00000000, 1'b0, 1'b1, 26};
    v[5] = '{32'h00000000, 32'hC0400000,
             32'h80000000, 1'b0, 1'b0, 1};
    v[6] = '{32'h7F800000, 32'h00000000,
             32'h7FC00000, 1'b0, 1'b0, 1};
    v[7] = '{32'h7FC00001, 32'h3F800000,
             32'h7FC00000, 1'b0, 1'b0, 1};
    v[8] = '{32'hFF800000, 32'h40000000,
             32'hFF800000, 1'b0, 1'b0, 1};
    v[9] = '{32'h3F800001, 32'h3F800001,
             32'h3F800002, 1'b0, 1'b0, 26};

    rst = 1'b1;
    iv1 = 1'b0; a1 = '0; b1 = '0; rd1 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; rd8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(ir1), 32'd1);
    chk("rst out_valid", 32'(ov1), 32'd0);
    chk("rst out", o1, 32'd0);
    chk("rst ovf", 32'(ovf1), 32'd0);
    chk("rst unf", 32'(unf1), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(1'b0, v[i].a, v[i].b, ro, rovf, runf, lat);
      chk($sformatf("v%0d out", i), ro, v[i].o);
      chk($sformatf("v%0d ovf", i),
          32'(rovf), 32'(v[i].ovf));
      chk($sformatf("v%0d unf", i),
          32'(runf), 32'(v[i].unf));
      chk($sformatf("v%0d lat", i),
          32'(lat), 32'(v[i].lat));
    end

    do_op(1'b1, 32'h40000000, 32'h40400000,
          ro, rovf, runf, lat);
    chk("bpc8 out", ro, 32'h40C00000);
    chk("bpc8 lat", 32'(lat), 32'd5);
    do_op(1'b1, 32'h3FC00000, 32'h3FC00000,
          ro, rovf, runf, lat);
    chk("bpc8 norm out", ro, 32'h40100000);

    // backpressure: hold result, ignore new operands
    rd1 = 1'b0;
    iv1 = 1'b1; a1 = 32'h40000000; b1 = 32'h40400000;
    @(posedge clk); #1;
    iv1 = 1'b0;
    w = 0;
    while (!ov1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp valid", 32'(ov1), 32'd1);
    iv1 = 1'b1; a1 = 32'h3F800000; b1 = 32'h3F800000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d out", k), o1, 32'h40C00000);
      chk($sformatf("bp%0d in_ready", k),
          32'(ir1), 32'd0);
      chk($sformatf("bp%0d out_valid", k),
          32'(ov1), 32'd1);
    end
    rd1 = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 32'(ov1), 32'd0);
    chk("bp release in_ready", 32'(ir1), 32'd1);
    iv1 = 1'b0;

    // reset during MUL drops the operation
    iv1 = 1'b1; a1 = 32'h40000000; b1 = 32'h40400000;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid in_ready busy", 32'(ir1), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid rst out_valid", 32'(ov1), 32'd0);
    chk("mid rst in_ready", 32'(ir1), 32'd1);
    chk("mid rst out", o1, 32'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (ov1) seen++;
    end
    chk("mid rst no result", 32'(seen), 32'd0);
    do_op(1'b0, 32'h40000000, 32'h40400000,
          ro, rovf, runf, lat);
    chk("post rst out", ro, 32'h40C00000);
    chk("post rst lat", 32'(lat), 32'd26);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
